tap_mac8: RTL and testbench

TAP_MAC8 -- requirements
Module: tap_mac8

---
 rtl/tap_mac8.sv | 133 +++++++++++++
 tb/tb_tap_mac8.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_mac8.sv
`default_nettype none
// ============================================================================
// Module      : tap_mac8
// Description : Sequential 8-tap signed dot product (one MAC per cycle) over a
//               snapshot of an upstream shift register, with a writable
//               coefficient bank. Optional output saturation: TAP_MAC8_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_mac8 (
    input  logic               Clock,
    input  logic               Reset,
    input  logic signed [15:0] A,
    input  logic signed [15:0] B,
    input  logic signed [15:0] C,
    input  logic signed [15:0] D,
    input  logic signed [15:0] E,
    input  logic signed [15:0] F,
    input  logic signed [15:0] G,
    input  logic signed [15:0] H,
    input  logic               Start,
    input  logic               Coef_we,
    input  logic [2:0]         Coef_addr,
    input  logic signed [15:0] Coef_din,
    output logic signed [31:0] Y,
    output logic               Valid,
    output logic               Busy,
    output logic               Ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_y_max = 32'h7FFF_FFFF;
    localparam logic [31:0] c_y_min = 32'h8000_0000;

    state_t             r_state;
    state_t             w_state_next;
    logic signed [15:0] r_tap  [8];
    logic signed [15:0] r_coef [8];
    logic signed [34:0] r_acc;
    logic [2:0]         r_idx;

    logic               w_start_ok;
    logic               w_last;
    logic signed [31:0] w_prod;
    logic signed [34:0] w_acc_next;
    logic [31:0]        w_y;
    logic               w_ovf;

    assign Busy       = (r_state == S_MAC);
    assign w_start_ok = Start && (r_state != S_MAC);
    assign w_last     = (r_state == S_MAC) && (r_idx == 3'd7);

    assign w_prod     = 32'(r_tap[r_idx]) * 32'(r_coef[r_idx]);
    assign w_acc_next = r_acc + 35'(w_prod);

`ifdef TAP_MAC8_SAT_EN
    // The result fits in 32 bits only when bits 34..31 are all equal.
    always_comb begin
        w_y   = w_acc_next[31:0];
        w_ovf = 1'b0;
        if (!((w_acc_next[34:31] == 4'b0000) || (w_acc_next[34:31] == 4'b1111))) begin
            w_ovf = 1'b1;
            w_y   = w_acc_next[34] ? c_y_min : c_y_max;
        end
    end
`else
    assign w_y   = w_acc_next[31:0];
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_next = S_MAC;
            S_MAC:   if (r_idx == 3'd7) w_state_next = S_DONE;
            S_DONE:  w_state_next = Start ? S_MAC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_acc <= '0;
            r_idx <= '0;
            Y     <= '0;
            Valid <= 1'b0;
            Ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_tap[i]  <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            Valid <= w_last;
            // Writes landing on the Start edge are visible to the first MAC step.
            if (Coef_we && !Busy) begin
                r_coef[Coef_addr] <= Coef_din;
            end
            if (w_start_ok) begin
                r_tap[0] <= A;
                r_tap[1] <= B;
                r_tap[2] <= C;
                r_tap[3] <= D;
                r_tap[4] <= E;
                r_tap[5] <= F;
                r_tap[6] <= G;
                r_tap[7] <= H;
                r_acc    <= '0;
                r_idx    <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + 3'd1;
                if (w_last) begin
                    Y   <= w_y;
                    Ovf <= w_ovf;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tap_mac8.sv
`default_nettype none
// Directed bench for tap_mac8: a vector table of full operations followed by
// hand-written sequences for in-flight disturbance, back-to-back and reset abort.
module tb_tap_mac8;

    typedef logic [7:0][15:0] word8_t;

    typedef struct packed {
        word8_t      coef;
        word8_t      tap;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

`ifdef TAP_MAC8_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] A = '0, B = '0, C = '0, D = '0, E = '0, F = '0, G = '0, H = '0;
    logic        Start = 1'b0;
    logic        Coef_we = 1'b0;
    logic [2:0]  Coef_addr = '0;
    logic [15:0] Coef_din = '0;
    logic [31:0] Y;
    logic        Valid;
    logic        Busy;
    logic        Ovf;

    int errors = 0;
    int checks = 0;

    vec_t vecs [9];

    tap_mac8 dut (
        .Clock(Clock), .Reset(Reset),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .Start(Start), .Coef_we(Coef_we), .Coef_addr(Coef_addr), .Coef_din(Coef_din),
        .Y(Y), .Valid(Valid), .Busy(Busy), .Ovf(Ovf)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic word8_t uniform(input logic [15:0] v);
        word8_t t;
        for (int k = 0; k < 8; k++) t[k] = v;
        return t;
    endfunction

    task automatic set_taps(input word8_t t);
        A = t[0]; B = t[1]; C = t[2]; D = t[3];
        E = t[4]; F = t[5]; G = t[6]; H = t[7];
    endtask

    task automatic write_coefs(input word8_t c);
        for (int k = 0; k < 8; k++) begin
            Coef_we   = 1'b1;
            Coef_addr = 3'(k);
            Coef_din  = c[k];
            tick();
        end
        Coef_we = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Called just after the acceptance edge; returns edges until Valid is seen.
    task automatic wait_valid(input string name, output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (!Valid && cyc < 30) begin
            if (Busy) busy_n++;
            tick();
            cyc++;
        end
        chk({name, "_valid_seen"}, {31'b0, Valid}, 32'd1);
    endtask

    task automatic run_vec(input int i);
        int    cyc;
        int    bn;
        string nm;
        nm = $sformatf("v%0d", i);
        write_coefs(vecs[i].coef);
        set_taps(vecs[i].tap);
        pulse_start();
        wait_valid(nm, cyc, bn);
        chk({nm, "_latency"}, 32'(cyc), 32'd8);
        chk({nm, "_busy_cycles"}, 32'(bn), 32'd8);
        chk({nm, "_y"}, Y, vecs[i].y);
        chk({nm, "_ovf"}, {31'b0, Ovf}, {31'b0, vecs[i].ovf});
        tick();
        chk({nm, "_valid_drop"}, {31'b0, Valid}, 32'd0);
        chk({nm, "_y_hold"}, Y, vecs[i].y);
    endtask

    initial begin
        int          cyc;
        int          bn;
        int          vcount;
        logic [31:0] yseen;
        word8_t      ramp;

        for (int k = 0; k < 8; k++) ramp[k] = 16'(k + 1);
        for (int i = 0; i < 9; i++) vecs[i] = '0;

        vecs[0].coef = uniform(16'd1);
        vecs[0].tap  = ramp;
        vecs[0].y    = 32'd36;

        for (int k = 0; k < 8; k++) vecs[1].coef[k] = 16'(k + 1);
        vecs[1].tap  = uniform(16'hFFFF);
        vecs[1].y    = 32'hFFFF_FFDC;

        vecs[2].coef = uniform(16'h7FFF);
        vecs[2].tap  = uniform(16'h7FFF);
        vecs[2].y    = SAT ? 32'h7FFF_FFFF : 32'hFFF8_0008;
        vecs[2].ovf  = SAT;

        vecs[3].coef = uniform(16'h8000);
        vecs[3].tap  = uniform(16'h7FFF);
        vecs[3].y    = SAT ? 32'h8000_0000 : 32'h0004_0000;
        vecs[3].ovf  = SAT;

        vecs[4].coef = uniform(16'h8000);
        vecs[4].tap  = uniform(16'h8000);
        vecs[4].y    = SAT ? 32'h7FFF_FFFF : 32'h0000_0000;
        vecs[4].ovf  = SAT;

        vecs[5].coef = {16'hFFF7, 16'd8, 16'hFFF9, 16'd6, 16'hFFFB, 16'd4, 16'hFFFD, 16'd2};
        for (int k = 0; k < 8; k++) vecs[5].tap[k] = 16'(100 * (k + 1));
        vecs[5].y    = 32'hFFFF_F060;

        // +2^31 exactly: one past the positive limit
        vecs[6].coef[0] = 16'h8000; vecs[6].tap[0] = 16'h8000;
        vecs[6].coef[1] = 16'h8000; vecs[6].tap[1] = 16'h8000;
        for (int k = 2; k < 8; k++) vecs[6].tap[k] = 16'h1234;
        vecs[6].y    = SAT ? 32'h7FFF_FFFF : 32'h8000_0000;
        vecs[6].ovf  = SAT;

        vecs[7].coef[0] = 16'h8000; vecs[7].tap[0] = 16'h8000;
        vecs[7].coef[1] = 16'h7FFF; vecs[7].tap[1] = 16'h7FFF;
        for (int k = 2; k < 8; k++) vecs[7].coef[k] = 16'd5;
        vecs[7].y    = 32'h7FFF_0001;

        // -2^31 exactly: representable, no clamp
        vecs[8].coef[0] = 16'h8000; vecs[8].tap[0] = 16'h7FFF;
        vecs[8].coef[1] = 16'h8000; vecs[8].tap[1] = 16'h7FFF;
        vecs[8].coef[2] = 16'hFF00; vecs[8].tap[2] = 16'h0100;
        vecs[8].y    = 32'h8000_0000;

        tick();
        tick();
        chk("rst_y", Y, 32'd0);
        chk("rst_valid", {31'b0, Valid}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_ovf", {31'b0, Ovf}, 32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(i);

        // Disturb taps, coefficients and Start while the MAC runs
        write_coefs(uniform(16'd1));
        set_taps(ramp);
        pulse_start();
        vcount = 0;
        yseen  = '0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) set_taps(uniform(16'h0100));
            if (c == 3) begin Coef_we = 1'b1; Coef_addr = 3'd2; Coef_din = 16'd99; end
            if (c == 4) begin Coef_we = 1'b0; Start = 1'b1; end
            if (c == 5) Start = 1'b0;
            if (Valid) begin vcount++; yseen = Y; end
            tick();
        end
        chk("dist_valid_count", 32'(vcount), 32'd1);
        chk("dist_y", yseen, 32'd36);
        set_taps(ramp);
        pulse_start();
        wait_valid("dist_coef", cyc, bn);
        chk("dist_coef_y", Y, 32'd36);

        // Coefficient write on the acceptance edge is used by that operation
        tick();
        Coef_we = 1'b1; Coef_addr = 3'd0; Coef_din = 16'd5;
        Start = 1'b1;
        tick();
        Coef_we = 1'b0; Start = 1'b0;
        wait_valid("same_edge", cyc, bn);
        chk("same_edge_y", Y, 32'd40);

        // Start held high: one result every 9 cycles, taps sampled at acceptance
        tick();
        write_coefs(uniform(16'd1));
        set_taps(uniform(16'd1));
        Start = 1'b1;
        tick();
        set_taps(uniform(16'd2));
        wait_valid("b2b_0", cyc, bn);
        chk("b2b_0_y", Y, 32'd8);
        tick();
        set_taps(uniform(16'd3));
        chk("b2b_0_pulse", {31'b0, Valid}, 32'd0);
        wait_valid("b2b_1", cyc, bn);
        chk("b2b_1_gap", 32'(cyc + 1), 32'd9);
        chk("b2b_1_y", Y, 32'd16);
        tick();
        Start = 1'b0;
        wait_valid("b2b_2", cyc, bn);
        chk("b2b_2_gap", 32'(cyc + 1), 32'd9);
        chk("b2b_2_y", Y, 32'd24);
        tick();

        // Reset mid-MAC, together with Start and a coefficient write
        set_taps(uniform(16'd1));
        pulse_start();
        tick(); tick(); tick();
        chk("abort_busy_before", {31'b0, Busy}, 32'd1);
        Reset = 1'b1; Start = 1'b1;
        Coef_we = 1'b1; Coef_addr = 3'd0; Coef_din = 16'd7;
        tick();
        Reset = 1'b0; Start = 1'b0; Coef_we = 1'b0;
        chk("abort_y", Y, 32'd0);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_valid", {31'b0, Valid}, 32'd0);
        chk("abort_ovf", {31'b0, Ovf}, 32'd0);
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            if (Valid) vcount++;
            tick();
        end
        chk("abort_no_valid", 32'(vcount), 32'd0);
        pulse_start();
        wait_valid("abort_zero", cyc, bn);
        chk("abort_zero_y", Y, 32'd0);
        tick();
        Coef_we = 1'b1; Coef_addr = 3'd0; Coef_din = 16'd3;
        tick();
        Coef_we = 1'b0;
        pulse_start();
        wait_valid("abort_coef", cyc, bn);
        chk("abort_coef_y", Y, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
